// File: rtl/axi_skid_slice.sv
// axi_skid_slice
//   Valid/ready register slice that breaks the combinational valid/ready
//   paths between two pipeline stages. Handshake outputs (in_ready,
//   out_valid) are decoded from the state register only.
//
//   MODE 0 : two-entry skid buffer, one transfer per cycle, registered ready.
//   MODE 1 : single-entry slice, accepts only when empty (half throughput).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   EMPTY | nothing held, out_valid low, in_ready high
//   ONE   | main register holds the head word, out_valid high
//   FULL  | main holds head, skid holds the next word (MODE 0 only)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload
//   occupancy                  words held (0..2)
//   stall_count, stall_clr     saturating count of out_valid & ~out_ready
//                              cycles, synchronous clear (clear wins)

module axi_skid_slice #(
    parameter int DATA_W = 16,
    parameter int MODE   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q;
    logic               ready_st;
    logic               in_fire;
    logic               out_fire;

    // The encoding 3 is treated as "not ready, not valid" so a corrupted
    // state can neither accept nor present a word before it recovers.
    always_comb begin
        ready_st = 1'b0;
        if (MODE == 0) begin
            ready_st = (state_q == EMPTY) || (state_q == ONE);
        end else begin
            ready_st = (state_q == EMPTY);
        end
    end

    // Ready is forced low while reset is asserted, independent of the clock.
    assign in_ready  = rst_n & ready_st;
    assign out_valid = (state_q == ONE) || (state_q == FULL);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (MODE == 0) begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (MODE == 0) begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end else begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_axi_skid_slice.sv
// Directed and randomised checks of axi_skid_slice in both modes.
// dut_a: MODE 0 with a 4-bit stall counter; dut_b: MODE 1 with 16 bits.

module tb_axi_skid_slice;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [3:0]  a_stall;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          delivered;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        a_hold, b_hold;
    logic [15:0] a_hold_data, b_hold_data, exp_w;
    logic [15:0] b_stall_model;

    always #5 clk = ~clk;

    axi_skid_slice #(.DATA_W(16), .MODE(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_count(a_stall), .stall_clr(a_stall_clr)
    );

    axi_skid_slice #(.DATA_W(16), .MODE(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_count(b_stall), .stall_clr(b_stall_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One scoreboarded cycle on both DUTs; drain forces idle upstream and
    // ready downstream.
    task automatic sb_cycle(input bit drain);
        chk("a_occ_model", a_occ, qa.size());
        chk("b_occ_model", b_occ, qb.size());
        if (a_hold) begin
            chk("a_hold_valid", a_out_valid, 1);
            chk("a_hold_data", a_out_data, a_hold_data);
        end
        if (b_hold) begin
            chk("b_hold_valid", b_out_valid, 1);
            chk("b_hold_data", b_out_data, b_hold_data);
        end
        a_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
        a_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
        a_in_data   = 16'($urandom);
        b_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
        b_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
        b_in_data   = 16'($urandom);
        a_hold      = a_out_valid & ~a_out_ready;
        a_hold_data = a_out_data;
        b_hold      = b_out_valid & ~b_out_ready;
        b_hold_data = b_out_data;
        if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        if (a_out_valid && a_out_ready) begin
            chk("a_pop_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                exp_w = qa.pop_front();
                chk("a_order", a_out_data, exp_w);
            end
        end
        if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        if (b_out_valid && b_out_ready) begin
            chk("b_pop_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                exp_w = qb.pop_front();
                chk("b_order", b_out_data, exp_w);
            end
        end
        if (b_out_valid && !b_out_ready && b_stall_model != 16'hFFFF)
            b_stall_model = b_stall_model + 16'd1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_out_ready = 0; a_in_data = '0; a_stall_clr = 0;
        b_in_valid = 0; b_out_ready = 0; b_in_data = '0; b_stall_clr = 0;
        a_hold = 0; b_hold = 0; a_hold_data = '0; b_hold_data = '0;
        b_stall_model = '0; delivered = 0; exp_w = '0;
        #1;
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data", a_out_data, 0);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_a_in_ready", a_in_ready, 1);
        chk("rel_b_in_ready", b_in_ready, 1);
        step();

        // MODE 0 streaming, one word per cycle
        a_in_valid = 1; a_out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = 16'(i);
            step();
            chk("stream_valid", a_out_valid, 1);
            chk("stream_data", a_out_data, i);
            chk("stream_occ", a_occ, 1);
        end
        a_in_valid = 0;
        step();
        chk("stream_end_occ", a_occ, 0);
        chk("stream_end_valid", a_out_valid, 0);
        chk("stream_stall", a_stall, 0);

        // MODE 0 fill to FULL under backpressure, then drain
        a_out_ready = 0; a_in_valid = 1; a_in_data = 16'hAAAA;
        step();
        chk("fill1_occ", a_occ, 1);
        chk("fill1_data", a_out_data, 16'hAAAA);
        chk("fill1_stall", a_stall, 0);
        a_in_data = 16'h5555;
        step();
        chk("fill2_occ", a_occ, 2);
        chk("fill2_in_ready", a_in_ready, 0);
        chk("fill2_data", a_out_data, 16'hAAAA);
        chk("fill2_stall", a_stall, 1);
        a_in_valid = 0;
        step();
        chk("full_data", a_out_data, 16'hAAAA);
        chk("full_stall", a_stall, 2);
        chk("full_occ", a_occ, 2);
        a_out_ready = 1;
        step();
        chk("drain1_data", a_out_data, 16'h5555);
        chk("drain1_in_ready", a_in_ready, 1);
        chk("drain1_occ", a_occ, 1);
        chk("drain1_stall", a_stall, 2);
        step();
        chk("drain2_valid", a_out_valid, 0);
        chk("drain2_occ", a_occ, 0);

        // 4-bit stall counter saturation and clear-over-increment
        a_stall_clr = 1; a_in_valid = 1; a_in_data = 16'h1234; a_out_ready = 0;
        step();
        a_in_valid = 0; a_stall_clr = 0;
        chk("sat_clr", a_stall, 0);
        chk("sat_occ", a_occ, 1);
        repeat (20) step();
        chk("sat_value", a_stall, 15);
        chk("sat_data", a_out_data, 16'h1234);
        a_stall_clr = 1;
        step();
        chk("clr_during_stall", a_stall, 0);
        a_stall_clr = 0;
        step();
        chk("count_after_clr", a_stall, 1);

        // asynchronous reset while FULL
        a_in_valid = 1; a_in_data = 16'hBEEF;
        step();
        a_in_valid = 0;
        chk("pre_rst_occ", a_occ, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", a_out_valid, 0);
        chk("arst_in_ready", a_in_ready, 0);
        chk("arst_occ", a_occ, 0);
        chk("arst_stall", a_stall, 0);
        chk("arst_data", a_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", a_in_ready, 1);
        chk("post_rst_valid", a_out_valid, 0);

        // MODE 1 half throughput
        b_out_ready = 1; b_in_valid = 1;
        for (int c = 0; c < 8; c++) begin
            chk("m1_in_ready", b_in_ready, (c % 2) == 0);
            b_in_data = 16'(16'h0100 + c / 2);
            if (b_out_valid && b_out_ready) delivered++;
            step();
            if ((c % 2) == 0) begin
                chk("m1_valid", b_out_valid, 1);
                chk("m1_data", b_out_data, 16'h0100 + c / 2);
            end else begin
                chk("m1_idle", b_out_valid, 0);
            end
        end
        b_in_valid = 0;
        chk("m1_delivered", delivered, 4);
        chk("m1_occ", b_occ, 0);

        // randomised traffic on both modes
        b_out_ready = 0;
        for (int n = 0; n < 10000; n++) sb_cycle(1'b0);
        for (int n = 0; n < 4; n++) sb_cycle(1'b1);
        chk("rand_a_left", qa.size(), 0);
        chk("rand_b_left", qb.size(), 0);
        chk("rand_a_occ", a_occ, 0);
        chk("rand_b_stall", b_stall, b_stall_model);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_skid_slice.md
Name: axi_skid_slice

Overview:
- Parametrised valid/ready register slice carrying a DATA_W payload between two handshake interfaces.
- MODE 0 is a two-entry skid buffer: full throughput, registered ready. MODE 1 is the single-entry, half-throughput hold-until-accepted slice.
- Exports buffer occupancy and a saturating stall counter for performance monitoring.
- Sits between pipeline stages in the datapath to break valid/ready timing paths.

Parameters:
- DATA_W, 16, payload width in bits (>=1).
- MODE, 0, 0 = full-throughput skid buffer; 1 = half-throughput single-entry slice.
- CNT_W, 16, stall counter width (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous reset, active-low; one clock, reset is asynchronous and active-low.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  slice can accept; in_fire = in_valid & in_ready.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  slice holds data for downstream.
- out_ready  input  1  downstream accepts; out_fire = out_valid & out_ready.
- out_data  output  DATA_W  downstream payload.
- occupancy  output  2  entries held: 0, 1 or 2 (2 only in MODE 0).
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- stall_clr  input  1  synchronous clear of stall_count.

Behaviour:
- States: EMPTY (occupancy 0), ONE (1), FULL (2). Main register drives out_data; skid register is MODE 0 only.
- Reset (rst_n low, asynchronous) forces:
  - state EMPTY, out_valid 0, out_data 0, skid 0, stall_count 0.
  - in_ready 0, gated combinationally while rst_n is low.
  - Reset mid-transfer discards held data with no output glitch beyond the reset.
- in_ready and out_valid are decoded from the state register only. No combinational path from in_valid or out_ready to any output.
- out_valid = (state != EMPTY).
- Latency: in_fire in cycle N gives out_valid=1 with that data in cycle N+1.
- Once asserted, out_valid stays high and out_data stays stable until out_fire.
- Ordering is strict FIFO; no data is dropped or duplicated.
- MODE 0, in_ready = (state != FULL):
  - EMPTY: in_fire -> main<=in_data, go to ONE.
  - ONE, in_fire & out_fire -> main<=in_data, stay ONE.
  - ONE, in_fire only -> skid<=in_data, go to FULL.
  - ONE, out_fire only -> go to EMPTY.
  - FULL: in_ready=0; out_fire -> main<=skid, go to ONE.
  - Sustained in_valid=out_ready=1 gives one transfer per cycle.
- MODE 1, in_ready = (state == EMPTY):
  - EMPTY: in_fire -> main<=in_data, go to ONE.
  - ONE: out_fire -> go to EMPTY.
  - Maximum throughput is one transfer per 2 cycles; FULL is unreachable.
- Stall counter:
  - Increments each cycle with out_valid & ~out_ready; saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment; the cleared value is 0 in the next cycle.
- Illegal state encoding (3) recovers to EMPTY on the next clock.

Test Plan:
- MODE 0, reset release, then in_valid=1 with data 0x0001..0x0008 on consecutive cycles and out_ready=1 throughout -> out_data 0x0001..0x0008 on 8 consecutive cycles starting one cycle after the first in_fire; occupancy stays 1.
- MODE 0, two words 0xAAAA and 0x5555 accepted with out_ready=0 -> occupancy 2, in_ready 0, out_data 0xAAAA stable, stall_count increments each cycle. Then out_ready=1 -> 0xAAAA then 0x5555, in_ready returns to 1 the cycle after the first out_fire.
- MODE 1, continuous in_valid with out_ready=1 -> in_ready alternates 1/0; 4 words are delivered in 8 cycles, in order.
- rst_n pulsed low asynchronously (mid-cycle) while FULL -> out_valid, in_ready, occupancy and stall_count go to 0 immediately. After release, in_ready=1 at the first clock edge.
- CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_count saturates at 15. stall_clr asserted in the same cycle as a stall -> count reads 0.
- Random in_valid/out_ready at 50% each over 10000 cycles, both modes -> output sequence equals input sequence, out_data never changes while out_valid & ~out_ready.
